// File: rtl/fourier_seq_ctrl_64.sv
// -----------------------------------------------------------------------------
// fourier_seq_ctrl_64
//
// Frame sequencer for a 64-bit RNS Fourier core. It loads N samples into the
// core, waits for the transform to finish, then streams N complex results out
// through a valid/ready handshake.
//
// Parameters
//   N        samples per frame (2 .. 2^16)
//   TIMEOUT  watchdog limit in COMPUTE cycles (only with FOURIER_SEQ_TIMEOUT_EN)
//
// Ports
//   clk, reset              clock, asynchronous active-low reset
//   start, abort            frame start pulse, synchronous frame abort
//   in_valid/in_data/in_ready    sample input stream (accepted only in LOAD)
//   core_op/core_addr/core_x     command, address and sample to the core
//   core_done/core_y_re/core_y_im  completion flag and result from the core
//   out_valid/out_ready/out_re/out_im/out_last  result output stream
//   busy, frame_done, err   status: not idle, end-of-frame pulse, timeout pulse
//
// Configuration
//   FOURIER_SEQ_TIMEOUT_EN  when defined, COMPUTE aborts with an err pulse if
//                           core_done does not arrive within TIMEOUT cycles;
//                           otherwise err is tied low and COMPUTE waits forever.
// -----------------------------------------------------------------------------
module fourier_seq_ctrl_64 #(
  parameter int unsigned N       = 10,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  output logic [1:0]  core_op,
  output logic [31:0] core_addr,
  output logic [63:0] core_x,
  input  logic        core_done,
  input  logic [63:0] core_y_re,
  input  logic [63:0] core_y_im,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_re,
  output logic [63:0] out_im,
  output logic        out_last,
  output logic        busy,
  output logic        frame_done,
  output logic        err
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_COMPUTE   = 3'd2;
  localparam logic [2:0] ST_READ_ADDR = 3'd3;
  localparam logic [2:0] ST_READ_HOLD = 3'd4;

  // Index of the last sample/result of a frame.
  localparam logic [31:0] LAST = 32'(N - 1);

  logic [2:0]  state;
  logic [31:0] count;   // samples accepted so far in LOAD

`ifdef FOURIER_SEQ_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);
  logic [31:0] wd_cnt;  // COMPUTE cycles already spent without core_done
`else
  // Watchdog is compiled out; the parameter is kept for interface stability.
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign err            = 1'b0;
`endif

  // Status outputs decode straight from the state register, so an
  // asynchronous reset clears them immediately together with the state.
  // NOTE: every output of an always_comb gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    core_op = 2'b00;
    case (state)
      ST_LOAD:                   core_op = 2'b01;
      ST_COMPUTE:                core_op = 2'b10;
      ST_READ_ADDR, ST_READ_HOLD: core_op = 2'b11;
      default:                   core_op = 2'b00;
    endcase
  end

  assign in_ready = (state == ST_LOAD);
  assign busy     = (state != ST_IDLE);
  // core_addr is frozen while a result is held, so out_last is stable too.
  assign out_last = (state == ST_READ_HOLD) && (core_addr == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      core_addr  <= '0;
      core_x     <= '0;
      out_re     <= '0;
      out_im     <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
`ifdef FOURIER_SEQ_TIMEOUT_EN
      wd_cnt     <= '0;
      err        <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
`ifdef FOURIER_SEQ_TIMEOUT_EN
      err        <= 1'b0;
`endif
      if (abort && (state != ST_IDLE)) begin
        // Abort beats any handshake in the same cycle and never reports done.
        state     <= ST_IDLE;
        count     <= '0;
        core_addr <= '0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state <= ST_LOAD;
              count <= '0;
            end
          end

          ST_LOAD: begin
            // in_ready is high for the whole of LOAD, so in_valid alone
            // marks an accepted sample.
            if (in_valid) begin
              core_x    <= in_data;
              core_addr <= count;
              count     <= count + 32'd1;
              if (count == LAST) begin
                state <= ST_COMPUTE;
`ifdef FOURIER_SEQ_TIMEOUT_EN
                wd_cnt <= '0;
`endif
              end
            end
          end

          ST_COMPUTE: begin
            if (core_done) begin
              core_addr <= '0;
              state     <= ST_READ_ADDR;
            end
`ifdef FOURIER_SEQ_TIMEOUT_EN
            else if (wd_cnt == WD_LAST) begin
              err       <= 1'b1;
              state     <= ST_IDLE;
              core_addr <= '0;
              count     <= '0;
            end else begin
              wd_cnt <= wd_cnt + 32'd1;
            end
`endif
          end

          ST_READ_ADDR: begin
            // The core has had one full cycle to present the addressed result.
            out_re    <= core_y_re;
            out_im    <= core_y_im;
            out_valid <= 1'b1;
            state     <= ST_READ_HOLD;
          end

          ST_READ_HOLD: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (core_addr == LAST) begin
                frame_done <= 1'b1;
                core_addr  <= '0;
                count      <= '0;
                state      <= ST_IDLE;
              end else begin
                core_addr <= core_addr + 32'd1;
                state     <= ST_READ_ADDR;
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fourier_seq_ctrl_64.sv
// -----------------------------------------------------------------------------
// tb_fourier_seq_ctrl_64
//
// Self-checking bench for fourier_seq_ctrl_64 (N=10, TIMEOUT=16). The bench
// plays the Fourier core (a sample memory plus a simple arithmetic "transform")
// and keeps a frame-level reference model that predicts every DUT output each
// cycle. Directed scenarios pin the model with literal expectations; a random
// phase then exercises starts, aborts, in_valid gaps, back-pressure and
// variable core latency.
// -----------------------------------------------------------------------------
module tb_fourier_seq_ctrl_64;

  localparam int N       = 10;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready;
  logic [1:0]  core_op;
  logic [31:0] core_addr;
  logic [63:0] core_x;
  logic        core_done = 1'b0;
  logic [63:0] core_y_re = '0, core_y_im = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_re, out_im;
  logic        out_last, busy, frame_done, err;

  fourier_seq_ctrl_64 #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .core_op(core_op), .core_addr(core_addr), .core_x(core_x),
    .core_done(core_done), .core_y_re(core_y_re), .core_y_im(core_y_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re),
    .out_im(out_im), .out_last(out_last), .busy(busy),
    .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Toy transform used by the core stand-in and by the reference model.
  function automatic logic [63:0] fn_re(input logic [63:0] a [N], input int k);
    logic [63:0] s = '0;
    for (int j = 0; j < N; j++) s += a[j] * 64'(j + k + 1);
    return s;
  endfunction

  function automatic logic [63:0] fn_im(input logic [63:0] a [N], input int k);
    if (k < 0 || k >= N) return '0;
    return a[k] * 64'd3 + 64'(k);
  endfunction

  // ---------------- Fourier core stand-in ----------------
  logic [63:0] mem [N];
  int done_delay  = 0;   // 0 = never signal done
  int comp_cycles = 0;

  // Advance one clock; at negedge+1 the core reacts to the current outputs.
  task automatic step();
    @(negedge clk);
    #1;
    if (core_op == 2'b10) begin
      comp_cycles++;
      core_done = (done_delay != 0) && (comp_cycles == done_delay);
    end else begin
      comp_cycles = 0;
      core_done   = 1'b0;
    end
    if ((core_op == 2'b01 || core_op == 2'b10) && core_addr < N) mem[core_addr] = core_x;
    core_y_re = fn_re(mem, int'(core_addr));
    core_y_im = fn_im(mem, int'(core_addr));
  endtask

  // ---------------- Reference model ----------------
  // Frame phases: where the current frame is, not how the RTL encodes it.
  localparam int P_IDLE = 0, P_LOAD = 1, P_COMP = 2, P_FETCH = 3, P_PRESENT = 4;
  int          ph = P_IDLE;
  int          m_cnt = 0, m_wd = 0;
  logic [31:0] m_addr = '0;
  logic [63:0] m_x = '0, m_re = '0, m_im = '0;
  logic        m_fd = 1'b0, m_err = 1'b0;
  logic [63:0] m_s [N];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph = P_IDLE; m_cnt = 0; m_wd = 0; m_addr = '0; m_x = '0;
      m_re = '0; m_im = '0; m_fd = 1'b0; m_err = 1'b0;
    end else begin
      m_fd = 1'b0;
      m_err = 1'b0;
      if (ph != P_IDLE && abort) begin
        ph = P_IDLE; m_cnt = 0; m_addr = '0;
      end else begin
        case (ph)
          P_IDLE: if (start) begin ph = P_LOAD; m_cnt = 0; end
          P_LOAD: if (in_valid) begin
            m_s[m_cnt] = in_data;
            m_x = in_data;
            m_addr = 32'(m_cnt);
            m_cnt++;
            if (m_cnt == N) begin ph = P_COMP; m_wd = 0; end
          end
          P_COMP: begin
            if (core_done) begin
              m_addr = '0; ph = P_FETCH;
            end
`ifdef FOURIER_SEQ_TIMEOUT_EN
            else begin
              m_wd++;
              if (m_wd == TIMEOUT) begin
                m_err = 1'b1; ph = P_IDLE; m_addr = '0; m_cnt = 0;
              end
            end
`endif
          end
          P_FETCH: begin
            m_re = fn_re(m_s, int'(m_addr));
            m_im = fn_im(m_s, int'(m_addr));
            ph = P_PRESENT;
          end
          P_PRESENT: if (out_ready) begin
            if (m_addr == 32'(N - 1)) begin
              m_fd = 1'b1; m_addr = '0; m_cnt = 0; ph = P_IDLE;
            end else begin
              m_addr = m_addr + 1; ph = P_FETCH;
            end
          end
          default: ph = P_IDLE;
        endcase
      end
    end
  end

  // Single compare process: every output against the model on every cycle.
  always @(negedge clk) begin
    logic [1:0] exp_op;
    exp_op = (ph == P_IDLE) ? 2'd0 : (ph == P_LOAD) ? 2'd1 : (ph == P_COMP) ? 2'd2 : 2'd3;
    check("busy", busy, ph != P_IDLE);
    check("in_ready", in_ready, ph == P_LOAD);
    check("core_op", core_op, exp_op);
    check("core_addr", core_addr, m_addr);
    check("core_x", core_x, m_x);
    check("out_valid", out_valid, ph == P_PRESENT);
    check("out_last", out_last, (ph == P_PRESENT) && (m_addr == 32'(N - 1)));
    check("out_re", out_re, m_re);
    check("out_im", out_im, m_im);
    check("frame_done", frame_done, m_fd);
    check("err", err, m_err);
  end

  // ---------------- Stimulus helpers ----------------
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input int n, input logic [63:0] base);
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_data = base + 64'(i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_frame_done(input int budget, input string name);
    int i = 0;
    while (!frame_done && i < budget) begin step(); i++; end
    check(name, frame_done, 1'b1);
  endtask

  // ---------------- Test sequence ----------------
  initial begin
    logic [63:0] cap_re, cap_im, arr [N];
    int nvalid, nlast, nfd, prev_idx, bad_spacing, first_valid, bad_err;
    logic [63:0] first_re, first_im;

    for (int i = 0; i < N; i++) begin mem[i] = '0; m_s[i] = '0; end
    #2 reset = 1'b0;
    step(); step();
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_core_x", core_x, 64'd0);
    reset = 1'b1;
    step();

    // Load samples 1..10 with in_valid high, including the start cycle.
    in_valid = 1'b1; in_data = 64'd1;
    do_start();
    check("load_in_ready", in_ready, 1'b1);
    check("load_no_early_accept", core_addr, 32'd0);
    done_delay = 20;
    out_ready  = 1'b1;
    for (int k = 0; k < N; k++) begin
      step();
      check("load_addr", core_addr, 32'(k));
      check("load_x", core_x, 64'(k + 1));
      in_data = 64'(k + 2);
    end
    in_valid = 1'b0;
    check("after_load_in_ready", in_ready, 1'b0);
    check("after_load_core_op", core_op, 2'b10);

    // Stream all results with out_ready high.
    nvalid = 0; nlast = 0; nfd = 0; prev_idx = -2; bad_spacing = 0; first_valid = 1;
    first_re = '0; first_im = '0;
    for (int c = 0; c < 120 && nfd == 0; c++) begin
      step();
      if (out_valid) begin
        if (first_valid) begin first_re = out_re; first_im = out_im; first_valid = 0; end
        else if (c - prev_idx != 2) bad_spacing++;
        prev_idx = c;
        nvalid++;
        if (out_last && nvalid != N) bad_spacing++;
        if (out_last) nlast++;
      end
      if (frame_done) begin
        nfd++;
        check("idle_after_frame", busy, 1'b0);
      end
    end
    check("result_count", 64'(nvalid), 64'(N));
    check("last_count", 64'(nlast), 64'd1);
    check("frame_done_count", 64'(nfd), 64'd1);
    check("result_spacing", 64'(bad_spacing), 64'd0);
    check("first_re", first_re, 64'd385);   // sum (j+1)^2, j=0..9
    check("first_im", first_im, 64'd3);

    // Back-pressure on result 3.
    do_start();
    feed(N, 64'd100);
    done_delay = 3;
    out_ready  = 1'b1;
    for (int i = 0; i < 60 && !(out_valid && core_addr == 32'd3); i++) step();
    check("hold_reached", out_valid && core_addr == 32'd3, 1'b1);
    for (int j = 0; j < N; j++) arr[j] = 64'd100 + 64'(j);
    check("hold_value", out_re, fn_re(arr, 3));
    cap_re = out_re; cap_im = out_im;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", out_valid, 1'b1);
      check("hold_re", out_re, cap_re);
      check("hold_im", out_im, cap_im);
      check("hold_addr", core_addr, 32'd3);
    end
    out_ready = 1'b1;
    wait_frame_done(60, "hold_frame_done");

    // Abort during LOAD after 4 samples, then a clean reload.
    do_start();
    feed(4, 64'd200);
    abort = 1'b1; in_valid = 1'b1; in_data = 64'd999;
    step();
    abort = 1'b0; in_valid = 1'b0;
    check("abort_in_ready", in_ready, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_addr", core_addr, 32'd0);
    do_start();
    in_valid = 1'b1; in_data = 64'd300;
    step();
    check("reload_addr", core_addr, 32'd0);
    check("reload_x", core_x, 64'd300);
    feed(N - 1, 64'd301);
    done_delay = 5;
    wait_frame_done(80, "reload_frame_done");

    // Core that never finishes.
    done_delay = 0;
    do_start();
    feed(N, 64'd1);
    check("stall_core_op", core_op, 2'b10);
`ifdef FOURIER_SEQ_TIMEOUT_EN
    bad_err = 0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      step();
      if (err) bad_err++;
    end
    check("timeout_no_early_err", 64'(bad_err), 64'd0);
    step();
    check("timeout_err", err, 1'b1);
    check("timeout_idle", busy, 1'b0);
`else
    bad_err = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (err) bad_err++;
    end
    check("no_watchdog_err", 64'(bad_err), 64'd0);
    check("no_watchdog_busy", busy, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("stall_abort_idle", busy, 1'b0);
`endif

    // Random traffic, checked cycle by cycle against the model.
    nfd = 0;
    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom_range(7) == 0);
      abort     = ($urandom_range(99) == 0);
      in_valid  = ($urandom_range(3) != 0);
      in_data   = {$urandom, $urandom};
      out_ready = $urandom_range(1);
      if (core_op != 2'b10) done_delay = $urandom_range(30, 1);
      step();
      if (frame_done) nfd++;
    end
    check("random_frames_completed", 64'(nfd > 0), 64'd1);
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;

    // Asynchronous reset while a result is held.
    out_ready = 1'b0; done_delay = 2;
    for (int i = 0; i < 200 && busy; i++) step();
    do_start();
    feed(N, 64'd50);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    check("pre_reset_valid", out_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_busy", busy, 1'b0);
    check("async_in_ready", in_ready, 1'b0);
    check("async_core_op", core_op, 2'b00);
    check("async_core_addr", core_addr, 32'd0);
    check("async_core_x", core_x, 64'd0);
    check("async_out_re", out_re, 64'd0);
    check("async_out_im", out_im, 64'd0);
    check("async_out_last", out_last, 1'b0);
    check("async_frame_done", frame_done, 1'b0);
    check("async_err", err, 1'b0);
    step();
    reset = 1'b1;
    step();
    check("post_reset_idle", busy, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not finish, limit 1000000 ns");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fourier_seq_ctrl_64.md
FOURIER_SEQ_CTRL_64 -- requirements
Module: fourier_seq_ctrl_64

Interface
REQ-001 SHALL have parameter N, default 10: samples per frame, range 2..2^16.
REQ-002 SHALL have parameter TIMEOUT, default 4096: max cycles in COMPUTE awaiting core_done; used only under REQ-030.
REQ-003 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low.
REQ-005 SHALL have ports start  input  1 (frame start pulse) and abort  input  1 (synchronous frame abort).
REQ-006 SHALL have ports in_valid  input  1, in_data  input  64 (sample, RNS-convertible int) and in_ready  output  1.
REQ-007 SHALL have ports core_op  output  2, core_addr  output  32 and core_x  output  64 (drive to the Fourier core).
REQ-008 SHALL have ports core_done  input  1, core_y_re  input  64 and core_y_im  input  64 (from the Fourier core, post-conversion).
REQ-009 SHALL have ports out_valid  output  1, out_ready  input  1, out_re  output  64, out_im  output  64 and out_last  output  1.
REQ-010 SHALL have ports busy  output  1, frame_done  output  1 (1-cycle pulse) and err  output  1 (1-cycle pulse).

Function
REQ-011 SHALL implement states IDLE, LOAD, COMPUTE, READ_ADDR, READ_HOLD; core_op = 00/01/10/11 in IDLE/LOAD/COMPUTE/READ_*.
REQ-012 IDLE: start=1 -> LOAD next cycle, sample counter cleared; start outside IDLE ignored.
REQ-013 LOAD: in_ready=1; each in_valid&in_ready cycle registers core_x<=in_data, core_addr<=count, count+=1.
REQ-014 LOAD: accepting sample N-1 -> COMPUTE next cycle; in_ready falls the same edge; no extra sample accepted.
REQ-015 in_ready SHALL be 0 in every state except LOAD; in_valid in IDLE (incl. same cycle as start) is not consumed.
REQ-016 COMPUTE: core_op=10 held until core_done=1 sampled -> READ_ADDR with core_addr=0.
REQ-017 READ_ADDR: one cycle; next edge captures core_y_re/core_y_im into out_re/out_im, asserts out_valid -> READ_HOLD.
REQ-018 READ_HOLD: out_valid, out_re, out_im, out_last stable until out_ready=1; out_last=1 iff core_addr==N-1.
REQ-019 READ_HOLD handshake, core_addr<N-1: out_valid<=0, core_addr+=1 -> READ_ADDR (2-cycle minimum per result).
REQ-020 READ_HOLD handshake, core_addr==N-1: out_valid<=0, frame_done pulse, core_addr<=0 -> IDLE.
REQ-021 abort=1 in any non-IDLE state -> IDLE next edge: out_valid=0, in_ready=0, core_op=00, counters 0; abort wins over simultaneous handshake; no frame_done.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 Counters 32 bits, compared against N-1; no wrap within a frame.

Reset
REQ-024 reset low SHALL immediately force state IDLE regardless of clk.
REQ-025 Reset values: core_op=00, core_addr=0, core_x=0, out_re=0, out_im=0, out_valid=0, out_last=0, in_ready=0, busy=0, frame_done=0, err=0.
REQ-026 Reset mid-frame SHALL discard all partial data; first edge after release is IDLE.

Configuration
REQ-030 Macro FOURIER_SEQ_TIMEOUT_EN defined: COMPUTE cycle counter; if core_done absent for TIMEOUT cycles -> err 1-cycle pulse, IDLE, core_op=00.
REQ-031 Macro undefined: no watchdog logic, err tied 0, COMPUTE waits indefinitely.

Verification
REQ-040 N=10, start, 10 samples 1..10 with in_valid always 1 -> core_addr 0..9 with core_x 1..10 on consecutive cycles; in_ready 0 after 10th; core_op=10.
REQ-041 core_done after 20 cycles, out_ready always 1 -> 10 results at 2-cycle spacing, out_last only on 10th, frame_done pulse, then IDLE.
REQ-042 out_ready held 0 for 5 cycles on result 3 -> out_re/out_im/out_valid stable for 5 cycles, core_addr stays 3.
REQ-043 abort during LOAD after 4 samples -> IDLE next edge, in_ready 0; new start reloads from core_addr 0.
REQ-044 reset low asynchronously mid-READ_HOLD -> out_valid 0 before next clk edge; all outputs at REQ-025 values.
REQ-045 FOURIER_SEQ_TIMEOUT_EN, TIMEOUT=16, core_done never -> err pulse 16 cycles after COMPUTE entry, IDLE; undefined: busy stays 1.
